// File: rtl/clk_div_meas.sv
// clk_div_meas: measures the period and high time of iSCLK in iCLK cycles, flags lock and stall.
// Define DUTY_MEAS_EN to build the high-time counter; without it oHIGH is tied to 0.
`timescale 1ns/1ps
module clk_div_meas #(
   parameter int WIDE     = 32,
   parameter int LOCK_CNT = 4
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iSCLK,
   input  logic            iEN,
   output logic [WIDE-1:0] oDIV,
   output logic [WIDE-1:0] oHIGH,
   output logic            oVALID,
   output logic            oLOCK,
   output logic            oTIMEOUT
);
   // state | meaning
   // IDLE  | disabled; counters cleared, results held
   // ARM   | waiting for the first rise to open a period
   // MEAS  | counting; every rise closes one period and opens the next
   typedef enum logic [1:0] {IDLE, ARM, MEAS} stateT;

   localparam int              MW       = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0]   LOCK_TGT = MW'(LOCK_CNT);
   localparam logic [WIDE-1:0] CNT_MAX  = '1;

   stateT           state, stateNext;
   logic            s1, s2, s3;
   logic            rise;
   logic [WIDE-1:0] cnt;
   logic [MW-1:0]   match, matchNext;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= iSCLK;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (iEN) stateNext = ARM;
         ARM:     if (rise) stateNext = MEAS;
         MEAS:    if (!rise && cnt == CNT_MAX) stateNext = ARM;
         default: stateNext = IDLE;
      endcase
      if (!iEN) stateNext = IDLE;
   end

   // Saturating run length of equal consecutive periods
   always_comb begin
      matchNext = MW'(1);
      if (cnt == oDIV && match != '0)
         matchNext = (match >= LOCK_TGT) ? LOCK_TGT : match + MW'(1);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt      <= '0;
         match    <= '0;
         oDIV     <= '0;
         oVALID   <= 1'b0;
         oLOCK    <= 1'b0;
         oTIMEOUT <= 1'b0;
      end else begin
         oVALID <= 1'b0;
         if (!iEN) begin
            cnt   <= '0;
            match <= '0;
            oLOCK <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  match <= '0;
               end
               ARM: if (rise) begin
                  cnt      <= WIDE'(1);
                  match    <= '0;
                  oTIMEOUT <= 1'b0;
               end
               MEAS: begin
                  if (rise) begin
                     oDIV   <= cnt;
                     oVALID <= 1'b1;
                     cnt    <= WIDE'(1);
                     match  <= matchNext;
                     oLOCK  <= (matchNext == LOCK_TGT);
                  end else if (cnt == CNT_MAX) begin
                     oTIMEOUT <= 1'b1;
                     oLOCK    <= 1'b0;
                     match    <= '0;
                  end else begin
                     cnt <= cnt + WIDE'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef DUTY_MEAS_EN
   logic            fall;
   logic [WIDE-1:0] hcnt, hold;

   assign fall = ~s2 & s3;

   // hcnt never exceeds cnt, so stopping it with cnt keeps it from wrapping
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         hcnt  <= '0;
         hold  <= '0;
         oHIGH <= '0;
      end else if (!iEN || state == IDLE) begin
         hcnt <= '0;
      end else if (state == ARM) begin
         if (rise) hcnt <= WIDE'(1);
      end else if (state == MEAS) begin
         if (rise) begin
            oHIGH <= hold;
            hcnt  <= WIDE'(1);
         end else begin
            if (fall) hold <= hcnt;
            if (s2 && cnt != CNT_MAX) hcnt <= hcnt + WIDE'(1);
         end
      end
   end
`else
   assign oHIGH = '0;
`endif

endmodule

// File: tb/tb_clk_div_meas.sv
// Bench for clk_div_meas: directed iSCLK ratios; expected results queued at each rise, checked on oVALID.
`timescale 1ns/1ps
module tb_clk_div_meas;
   localparam int WIDE     = 8;
   localparam int LOCK_CNT = 4;
`ifdef DUTY_MEAS_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic            iCLK = 1'b0;
   logic            iRST, iSCLK, iEN;
   logic [WIDE-1:0] oDIV, oHIGH;
   logic            oVALID, oLOCK, oTIMEOUT;

   typedef struct {
      int div;
      int high;
      bit lock;
   } expT;

   expT sb[$];
   expT cur;
   int  total = 0, bad = 0;
   int  cyc = 0, lastValidCyc = 0, validCnt = 0;
   bit  prevValid = 1'b0;
   bit  havePrev;
   int  prevN, prevH;
   bit  tSeen;
   int  v0;

   clk_div_meas #(.WIDE(WIDE), .LOCK_CNT(LOCK_CNT)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSCLK(iSCLK), .iEN(iEN),
      .oDIV(oDIV), .oHIGH(oHIGH), .oVALID(oVALID), .oLOCK(oLOCK), .oTIMEOUT(oTIMEOUT)
   );

   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void pushExp(input int n, input int h, input bit lk);
      expT e;
      e.div  = n;
      e.high = DUTY ? h : 0;
      e.lock = lk;
      sb.push_back(e);
   endfunction

   // Monitor: every oVALID consumes one queued expectation
   always @(negedge iCLK) begin
      if (oVALID) begin
         validCnt++;
         lastValidCyc = cyc;
         check("valid_one_cycle", prevValid, 0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got oDIV=%0d with no expected entry (cycle %0d)", oDIV, cyc);
         end else begin
            cur = sb.pop_front();
            check("div", oDIV, cur.div);
            check("high", oHIGH, cur.high);
            check("lock", oLOCK, cur.lock);
         end
      end
      prevValid = oVALID;
   end

   task automatic period(input int n, input int h);
      for (int j = 0; j < n; j++) begin
         iSCLK = (j < h);
         @(negedge iCLK);
      end
   endtask

   // Each rise closes the previous period: queue its result, lock bit taken from lockMask[i]
   task automatic run(input int n, input int h, input int count, input int lockMask);
      for (int i = 0; i < count; i++) begin
         if (havePrev) pushExp(prevN, prevH, lockMask[i]);
         period(n, h);
         prevN    = n;
         prevH    = h;
         havePrev = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      iRST = 1'b1; iEN = 1'b0; iSCLK = 1'b0; havePrev = 1'b0;
      repeat (3) @(negedge iCLK);
      check("rst_div", oDIV, 0);
      check("rst_high", oHIGH, 0);
      check("rst_valid", oVALID, 0);
      check("rst_lock", oLOCK, 0);
      check("rst_timeout", oTIMEOUT, 0);

      iRST = 1'b0; iEN = 1'b1;
      repeat (3) @(negedge iCLK);

      // ratio 6, lock from 4th result
      run(6, 3, 7, 'h70);
      check("lock_ratio6", oLOCK, 1);
      // odd ratio 5
      run(5, 2, 6, 'h31);
      check("lock_ratio5", oLOCK, 1);
      // back to 6, relock, then change to 10
      run(6, 3, 5, 'h11);
      check("lock_before_change", oLOCK, 1);
      run(10, 5, 5, 'h11);
      check("lock_ratio10", oLOCK, 1);

      // stall: iSCLK held low
      iSCLK = 1'b0;
      tSeen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge iCLK);
         if (oTIMEOUT && !tSeen) begin
            tSeen = 1'b1;
            check("timeout_delay", cyc - lastValidCyc, 255);
            check("timeout_lock", oLOCK, 0);
            check("timeout_div_held", oDIV, 10);
         end
      end
      check("timeout_seen", tSeen, 1);
      check("timeout_sticky", oTIMEOUT, 1);

      // restart at ratio 6: first rise arms and clears timeout
      havePrev = 1'b0;
      v0 = validCnt;
      run(6, 3, 1, 0);
      check("timeout_cleared", oTIMEOUT, 0);
      check("no_valid_on_arm_rise", validCnt, v0);
      run(6, 3, 5, 'h18);

      // enable drop mid-period while locked
      pushExp(6, 3, 1);
      iSCLK = 1'b1;
      repeat (3) @(negedge iCLK);
      iSCLK = 1'b0; iEN = 1'b0;
      repeat (3) @(negedge iCLK);
      check("drop_lock", oLOCK, 0);
      check("drop_div_held", oDIV, 6);
      iEN = 1'b1;
      repeat (2) @(negedge iCLK);
      havePrev = 1'b0;
      v0 = validCnt;
      run(6, 3, 1, 0);
      check("no_valid_after_reenable", validCnt, v0);
      run(6, 3, 5, 'h18);
      check("locked_before_reset", oLOCK, 1);

      // reset mid-run, then ratio 1 (iSCLK sampled as constant high)
      iRST = 1'b1; iSCLK = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
      check("midrst_div", oDIV, 0);
      check("midrst_high", oHIGH, 0);
      check("midrst_valid", oVALID, 0);
      check("midrst_lock", oLOCK, 0);
      check("midrst_timeout", oTIMEOUT, 0);
      v0 = validCnt;
      tSeen = 1'b0;
      for (int k = 0; k < 400 && !tSeen; k++) begin
         @(negedge iCLK);
         if (oTIMEOUT) tSeen = 1'b1;
      end
      check("ratio1_timeout", tSeen, 1);
      check("ratio1_no_valid", validCnt, v0);

      repeat (4) @(negedge iCLK);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_div_meas.md
# clk_div_meas

- Measures a divided clock against the system clock and reports the division ratio.
- The divided clock is derived from `iCLK` (for example, by a clock divider elsewhere in the design). `iSCLK` is sampled in the `iCLK` domain.
- For each `iSCLK` period the block reports:
  - the period length in `iCLK` cycles,
  - the high time in `iCLK` cycles,
  - a lock flag once the ratio is stable.
- Used as the checker/recovery end of the divider path: self-test of programmable divide ratios and detection of a stalled divided clock.

## Interface
- `WIDE`, 32, width of period/high-time counters and outputs
- `LOCK_CNT`, 4, consecutive equal periods required for lock (≥2)

- `iCLK`  in  1  sampling/reference clock; all logic on its rising edge
- `iRST`  in  1  reset, synchronous, active-high
- `iSCLK`  in  1  clock under measurement, asynchronous to sampling
- `iEN`  in  1  measurement enable
- `oDIV`  out  WIDE  last measured period, in `iCLK` cycles
- `oHIGH`  out  WIDE  high time of last measured period
- `oVALID`  out  1  one-cycle pulse when `oDIV`/`oHIGH` update
- `oLOCK`  out  1  period stable for `LOCK_CNT` consecutive measurements
- `oTIMEOUT`  out  1  no `iSCLK` rising edge within 2^WIDE−1 cycles; sticky

## Operation
- **Reset values:**
  - `oDIV=0`, `oHIGH=0`, `oVALID=0`, `oLOCK=0`, `oTIMEOUT=0`.
  - Synchronizer flops `s1`, `s2`, `s3` = 0.
  - `cnt`, `hcnt`, `match` = 0; state = IDLE.
- **Synchronizer:** `s1 <= iSCLK`, `s2 <= s1`, `s3 <= s2`.
  - `rise = s2 & ~s3`.
  - `fall = ~s2 & s3`.
- **States:**
  - IDLE: counters cleared, outputs held. Go to ARM when `iEN=1`.
  - ARM: wait for the first `rise`. On `rise`: `cnt<=1`, `hcnt<=1`, `match<=0`, `oTIMEOUT<=0`, go to MEAS. No `oVALID`.
  - MEAS:
    - `cnt<=cnt+1` every cycle; `hcnt<=hcnt+1` while `s2=1`.
    - On `fall`: `hold<=hcnt`.
    - On `rise`: `oDIV<=cnt`, `oHIGH<=hold`, `oVALID<=1`, `cnt<=1`, `hcnt<=1`.
  - `iEN=0` in any state: go to IDLE next cycle.
    - Clears `oLOCK`, `match`, `cnt`.
    - `oDIV`, `oHIGH` and `oTIMEOUT` hold.
- **Lock:** on each MEAS `rise`:
  - If `cnt==oDIV` and `match≠0`: `match<=min(match+1, LOCK_CNT)`.
  - Otherwise: `match<=1`.
  - `oLOCK<=(next match==LOCK_CNT)`. `oLOCK` updates in the same cycle as `oVALID`.
- **Timeout:** in MEAS, with no `rise` and `cnt` = all-ones:
  - `oTIMEOUT<=1`, `oLOCK<=0`, `match<=0`, go to ARM.
  - `oTIMEOUT` clears only on the next ARM `rise` or on `iRST`.
- **Width rules:**
  - `cnt` never wraps.
  - A `rise` in the cycle where `cnt` is all-ones is a normal measurement (`oDIV`=all-ones, no timeout).
- **Priority:** `iRST` > `iEN=0` > timeout/`rise`.
- **Measurable range:**
  - Minimum period is 2 `iCLK` cycles.
  - `iSCLK==iCLK` (ratio 1) is not measurable and shall end in timeout.
  - Results are exact only for `iSCLK` generated synchronously from `iCLK`. Asynchronous sources give ±1 jitter.

## Timing
- An `iSCLK` rising edge sampled at `iCLK` edge N gives `rise` at N+2 and `oVALID` high during cycle N+3, for exactly one cycle.
- `oDIV` and `oHIGH` are registered and stable from `oVALID` until the next `oVALID`.
- First `oVALID` after entering MEAS comes at the second observed rising edge.
- `oLOCK` first asserts on the `LOCK_CNT`-th `oVALID` of a constant ratio. It drops on the first mismatching `oVALID`.
- `iRST` mid-measurement: all outputs are at reset values in the cycle after the reset edge.

## Configuration
- Macro: `DUTY_MEAS_EN`.
  - **Defined:** `hcnt`/`hold` logic is present and `oHIGH` reports the high time as above.
  - **Undefined:** `hcnt`/`hold` logic is removed, `oHIGH` is tied to 0, and `fall` is unused. All other behaviour is identical.

## Test plan
Bench parameters: `WIDE=8`, `LOCK_CNT=4`. `iSCLK` is generated from an `iCLK` counter.
- **Ratio 6.** Reset, `iEN=1`, ratio 6 (3 high/3 low) → `oVALID` every 6 cycles with `oDIV=6`, `oHIGH=3`; `oLOCK=1` from the 4th `oVALID`. Without `DUTY_MEAS_EN`: `oHIGH=0`.
- **Odd ratio 5.** 2 high/3 low → `oDIV=5`, `oHIGH=2`, lock after 4 periods.
- **Ratio change.** Switch 6→10 mid-run → one transitional `oDIV`, then `oLOCK` drops at the first mismatch; `oLOCK` reasserts at the 4th consecutive `oDIV=10`.
- **Stall.** Hold `iSCLK` low 300 cycles in MEAS → `oTIMEOUT=1` and `oLOCK=0` 255 cycles after the last `rise`, `oDIV` held. Restart ratio 6 → `oTIMEOUT` clears on the first rise; first `oVALID` (`oDIV=6`) on the second rise.
- **Enable drop.** Drop `iEN` for 3 cycles mid-period → `oLOCK=0`, `oDIV` unchanged; after re-enable, no `oVALID` until two rises are seen.
- **Reset mid-run.** Assert `iRST` for 1 cycle while locked → next cycle all outputs 0; ratio 1 (`iSCLK=iCLK`) → `oTIMEOUT` after 255 cycles, no `oVALID`.
